// File: rtl/two_phase_clock_monitor.sv
// Receive-side monitor for the two-phase CPU clock pins: synchronises phi1/phi2,
// tracks the phi1 -> phi2 sequence, measures phase widths and flags faults.
module two_phase_clock_monitor #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 255,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             CLK_IN,
  input  logic             RES_N,
  input  logic             phi1_in,
  input  logic             phi2_in,
  input  logic             clear_err,
  output logic             cycle_strobe,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] phi1_width,
  output logic [CNT_W-1:0] phi2_width,
  output logic             locked,
  output logic             overlap_err,
  output logic             seq_err,
  output logic             stall_err
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {HUNT, P1_HI, GAP_A, P2_HI, GAP_B} state_t;

  // Index 0 is phi1, index 1 is phi2 throughout.
  logic [1:0] phi_pin, meta_q, sync_q, dly_q, rise, fall, accept;
  logic       any_edge, overlap, stall_hit, seq_hit, ovl_hit, fault, enter_hunt;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idle_q, idle_d, count_q, count_d;
  logic [LW-1:0]    good_q, good_d;
  logic             strobe_q, strobe_d, locked_q, locked_d;
  logic             ovl_err_q, ovl_err_d, seq_err_q, seq_err_d, stall_err_q, stall_err_d;

  assign phi_pin  = {phi2_in, phi1_in};
  assign rise     = sync_q & ~dly_q;
  assign fall     = ~sync_q & dly_q;
  assign any_edge = |(rise | fall);
  assign overlap  = &sync_q;

  always_ff @(posedge CLK_IN or negedge RES_N) begin
    if (!RES_N) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      meta_q <= phi_pin;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  // Idle timer parks at TIMEOUT so the stall fault fires once per silence.
  assign stall_hit = !any_edge && (idle_q == TO_VAL - 1'b1);

  always_comb begin
    idle_d = idle_q;
    if (any_edge)              idle_d = '0;
    else if (idle_q != TO_VAL) idle_d = idle_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    seq_hit  = 1'b0;
    ovl_hit  = 1'b0;
    strobe_d = 1'b0;
    case (state_q)
      HUNT:  if (rise[0] && !sync_q[1]) state_d = P1_HI;
      P1_HI: begin
        if (fall[0])      state_d = rise[1] ? P2_HI : GAP_A;
        else if (rise[1]) seq_hit = 1'b1;
      end
      GAP_A: begin
        if (rise[0])      seq_hit = 1'b1;
        else if (rise[1]) state_d = P2_HI;
      end
      P2_HI: begin
        if (fall[1]) begin
          strobe_d = 1'b1;
          state_d  = rise[0] ? P1_HI : GAP_B;
        end else if (rise[0]) begin
          seq_hit = 1'b1;
        end
      end
      GAP_B: begin
        if (rise[1])      seq_hit = 1'b1;
        else if (rise[0]) state_d = P1_HI;
      end
      default: state_d = HUNT;
    endcase
    // Overlap outranks a sequence fault seen in the same sample.
    if (state_q != HUNT && overlap) begin
      ovl_hit  = 1'b1;
      seq_hit  = 1'b0;
      strobe_d = 1'b0;
    end
    if (ovl_hit || seq_hit || stall_hit) state_d = HUNT;
  end

  assign fault      = ovl_hit | seq_hit | stall_hit;
  assign enter_hunt = (state_d == HUNT) && (state_q != HUNT);
  assign accept[0]  = (state_d == P1_HI) && (state_q != P1_HI);
  assign accept[1]  = (state_d == P2_HI) && (state_q != P2_HI);

  always_comb begin
    good_d = good_q;
    if (fault || enter_hunt)               good_d = '0;
    else if (strobe_d && good_q != LOCK_MAX) good_d = good_q + 1'b1;
    locked_d    = (good_d == LOCK_MAX);
    count_d     = count_q + CNT_W'(strobe_d);
    ovl_err_d   = ovl_hit   | (ovl_err_q   & ~clear_err);
    seq_err_d   = seq_hit   | (seq_err_q   & ~clear_err);
    stall_err_d = stall_hit | (stall_err_q & ~clear_err);
  end

  always_ff @(posedge CLK_IN or negedge RES_N) begin
    if (!RES_N) begin
      state_q     <= HUNT;
      idle_q      <= '0;
      count_q     <= '0;
      good_q      <= '0;
      strobe_q    <= 1'b0;
      locked_q    <= 1'b0;
      ovl_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      count_q     <= count_d;
      good_q      <= good_d;
      strobe_q    <= strobe_d;
      locked_q    <= locked_d;
      ovl_err_q   <= ovl_err_d;
      seq_err_q   <= seq_err_d;
      stall_err_q <= stall_err_d;
    end
  end

  // A width is only armed by a rise the FSM accepted, so phases already in
  // progress at reset or while hunting are never reported.
  for (genvar gi = 0; gi < 2; gi++) begin : g_width
    logic [CNT_W-1:0] cnt_q, cnt_d, width_q, width_d;
    logic             armed_q, armed_d;

    always_comb begin
      cnt_d   = cnt_q;
      width_d = width_q;
      armed_d = armed_q;
      if (accept[gi]) begin
        cnt_d   = CNT_W'(1);
        armed_d = 1'b1;
      end else if (fall[gi]) begin
        if (armed_q) width_d = cnt_q;
        cnt_d   = '0;
        armed_d = 1'b0;
      end else if (armed_q && sync_q[gi] && cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLK_IN or negedge RES_N) begin
      if (!RES_N) begin
        cnt_q   <= '0;
        width_q <= '0;
        armed_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        width_q <= width_d;
        armed_q <= armed_d;
      end
    end
  end

  assign cycle_strobe = strobe_q;
  assign cycle_count  = count_q;
  assign phi1_width   = g_width[0].width_q;
  assign phi2_width   = g_width[1].width_q;
  assign locked       = locked_q;
  assign overlap_err  = ovl_err_q;
  assign seq_err      = seq_err_q;
  assign stall_err    = stall_err_q;

endmodule

// File: tb/tb_two_phase_clock_monitor.sv
// Scoreboard bench: instance a (CNT_W=8, TIMEOUT=20) covers sequencing and faults,
// instance b (CNT_W=4, TIMEOUT=15) covers width saturation and count wrap.
module tb_two_phase_clock_monitor;

  logic CLK_IN = 1'b0;
  logic RES_N;
  logic phi1_a, phi2_a, clr_a, phi1_b, phi2_b, clr_b;

  logic       strobe_a, locked_a, ovl_a, seq_a, stall_a;
  logic [7:0] count_a, w1_a, w2_a;
  logic       strobe_b, locked_b, ovl_b, seq_b, stall_b;
  logic [3:0] count_b, w1_b, w2_b;

  typedef struct {
    int cnt;
    int w1;
    int w2;
    int lk;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK_IN = ~CLK_IN;

  two_phase_clock_monitor #(.CNT_W(8), .TIMEOUT(20), .LOCK_CYCLES(4)) u_dut_a (
    .CLK_IN(CLK_IN), .RES_N(RES_N), .phi1_in(phi1_a), .phi2_in(phi2_a),
    .clear_err(clr_a), .cycle_strobe(strobe_a), .cycle_count(count_a),
    .phi1_width(w1_a), .phi2_width(w2_a), .locked(locked_a),
    .overlap_err(ovl_a), .seq_err(seq_a), .stall_err(stall_a)
  );

  two_phase_clock_monitor #(.CNT_W(4), .TIMEOUT(15), .LOCK_CYCLES(4)) u_dut_b (
    .CLK_IN(CLK_IN), .RES_N(RES_N), .phi1_in(phi1_b), .phi2_in(phi2_b),
    .clear_err(clr_b), .cycle_strobe(strobe_b), .cycle_count(count_b),
    .phi1_width(w1_b), .phi2_width(w2_b), .locked(locked_b),
    .overlap_err(ovl_b), .seq_err(seq_b), .stall_err(stall_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  task automatic drive(input bit sel, input logic a, input logic b, input int n);
    if (sel) begin phi1_b = a; phi2_b = b; end
    else     begin phi1_a = a; phi2_a = b; end
    repeat (n) @(posedge CLK_IN);
    #2;
  endtask

  // One gap-free phi1/phi2 cycle; the strobe it causes is queued as expected.
  task automatic run_cycle(input bit sel, input int p1, input int p2,
                           input int cnt, input int w1, input int lk);
    exp_t e;
    e.cnt = cnt; e.w1 = w1; e.w2 = p2; e.lk = lk;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    drive(sel, 1'b1, 1'b0, p1);
    drive(sel, 1'b0, 1'b1, p2);
    if (sel) begin phi1_b = 1'b0; phi2_b = 1'b0; end
    else     begin phi1_a = 1'b0; phi2_a = 1'b0; end
  endtask

  task automatic pulse_clear_a();
    clr_a = 1'b1;
    @(posedge CLK_IN);
    #2 clr_a = 1'b0;
    @(negedge CLK_IN);
  endtask

  task automatic compare_strobe(input string tag, input exp_t e, input int cnt,
                                input int w1, input int w2, input int lk);
    n_tests++;
    if (cnt !== e.cnt || w1 !== e.w1 || w2 !== e.w2 || lk !== e.lk) begin
      n_fail++;
      $display("[TB] FAIL strobe_%s: got cnt=%0d w1=%0d w2=%0d lk=%0d, expected cnt=%0d w1=%0d w2=%0d lk=%0d",
               tag, cnt, w1, w2, lk, e.cnt, e.w1, e.w2, e.lk);
    end else begin
      $display("[TB] strobe_%s cnt=%0d w1=%0d w2=%0d lk=%0d", tag, cnt, w1, w2, lk);
    end
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge CLK_IN);
      if (strobe_a === 1'b1) begin
        if (q_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL strobe_a: unexpected strobe at cnt=%0d, expected none", count_a);
        end else begin
          e = q_a.pop_front();
          compare_strobe("a", e, count_a, w1_a, w2_a, locked_a);
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge CLK_IN);
      if (strobe_b === 1'b1) begin
        if (q_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL strobe_b: unexpected strobe at cnt=%0d, expected none", count_b);
        end else begin
          e = q_b.pop_front();
          compare_strobe("b", e, count_b, w1_b, w2_b, locked_b);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    RES_N = 1'b0;
    phi1_a = 0; phi2_a = 0; clr_a = 0;
    phi1_b = 0; phi2_b = 0; clr_b = 0;
    repeat (3) @(posedge CLK_IN);
    @(negedge CLK_IN);
    check("reset count", count_a, 0);
    check("reset locked", locked_a, 0);
    check("reset errs", {ovl_a, seq_a, stall_a}, 0);
    @(posedge CLK_IN);
    #2 RES_N = 1'b1;
    drive(0, 1'b0, 1'b0, 2);

    // 1: ten clean cycles, lock on the 4th strobe
    for (int i = 1; i <= 10; i++) run_cycle(0, 6, 6, i, 6, (i >= 4) ? 1 : 0);
    drive(0, 1'b0, 1'b0, 5);
    check("clean count", count_a, 10);
    check("clean phi1_width", w1_a, 6);
    check("clean phi2_width", w2_a, 6);
    check("clean errs", {ovl_a, seq_a, stall_a}, 0);

    // 2: overlap for two samples after lock
    drive(0, 1'b1, 1'b1, 2);
    phi1_a = 1'b0; phi2_a = 1'b0;
    @(negedge CLK_IN);
    check("pre-overlap locked", locked_a, 1);
    check("pre-overlap flag", ovl_a, 0);
    @(negedge CLK_IN);
    check("overlap flag", ovl_a, 1);
    check("overlap locked", locked_a, 0);
    drive(0, 1'b0, 1'b0, 2);
    for (int i = 11; i <= 14; i++) run_cycle(0, 6, 6, i, 6, (i == 14) ? 1 : 0);
    drive(0, 1'b0, 1'b0, 5);
    check("overlap sticky", ovl_a, 1);
    check("relocked", locked_a, 1);
    pulse_clear_a();
    check("overlap cleared", ovl_a, 0);

    // 3: two phi1 pulses without phi2
    drive(0, 1'b1, 1'b0, 6);
    drive(0, 1'b0, 1'b0, 6);
    drive(0, 1'b1, 1'b0, 6);
    drive(0, 1'b0, 1'b0, 5);
    check("seq flag", seq_a, 1);
    check("seq count held", count_a, 14);
    check("seq locked", locked_a, 0);
    check("seq no overlap", ovl_a, 0);
    pulse_clear_a();
    check("seq cleared", seq_a, 0);

    // 4: stall exactly 20 samples after the last synced edge, clear_err collides
    for (int i = 15; i <= 18; i++) run_cycle(0, 6, 6, i, 6, (i == 18) ? 1 : 0);
    repeat (22) @(posedge CLK_IN);
    @(negedge CLK_IN);
    check("pre-stall flag", stall_a, 0);
    check("pre-stall locked", locked_a, 1);
    clr_a = 1'b1;
    @(posedge CLK_IN);
    #2 clr_a = 1'b0;
    @(negedge CLK_IN);
    check("stall flag over clear", stall_a, 1);
    check("stall locked", locked_a, 0);
    repeat (3) @(negedge CLK_IN);
    check("stall sticky", stall_a, 1);

    // 5: narrow counters wrap and saturate
    @(posedge CLK_IN);
    #2;
    for (int i = 1; i <= 17; i++) run_cycle(1, 3, 3, i % 16, 3, (i >= 4) ? 1 : 0);
    drive(1, 1'b0, 1'b0, 5);
    check("wrap count", count_b, 1);
    check("wrap locked", locked_b, 1);
    drive(1, 1'b1, 1'b0, 20);
    drive(1, 1'b0, 1'b0, 5);
    check("saturated phi1_width", w1_b, 15);
    check("long phase locked", locked_b, 0);

    // 6: reset while phi2 is high
    drive(0, 1'b1, 1'b0, 6);
    drive(0, 1'b0, 1'b1, 5);
    check("pre-reset count", count_a, 18);
    @(negedge CLK_IN);
    RES_N = 1'b0;
    #1;
    check("async reset count", count_a, 0);
    check("async reset widths", {w1_a, w2_a}, 0);
    check("async reset flags", {strobe_a, locked_a, ovl_a, seq_a, stall_a}, 0);
    repeat (2) @(posedge CLK_IN);
    #2 RES_N = 1'b1;
    drive(0, 1'b0, 1'b1, 4);
    drive(0, 1'b0, 1'b0, 5);
    check("partial phi2 not loaded", w2_a, 0);
    check("no strobe after partial", count_a, 0);
    run_cycle(0, 6, 6, 1, 6, 0);
    drive(0, 1'b0, 1'b0, 5);
    check("first post-reset count", count_a, 1);

    check("queue a drained", q_a.size(), 0);
    check("queue b drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
